// File: rtl/order_issue_stage_pkg.sv
// Shared types for the order issue stage: physical register sizing, the uop
// base and option-code structs, the skid buffer state encoding and the
// writeback bypass match helper.
package order_issue_stage_pkg;

  localparam int PHY_REG_NUM = 64;
  localparam int PREG_W      = $clog2(PHY_REG_NUM);
  localparam int WB_WIDTH    = 2;
  localparam int ROB_W       = 5;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t            psrc0;
    preg_t            psrc1;
    logic             psrc0_valid;
    logic             psrc1_valid;
    preg_t            pdest;
    logic             pdest_valid;
    logic [ROB_W-1:0] rob_idx;
  } IssueBaseSt;

  typedef struct packed {
    logic [3:0] opcode;
    logic       use_imm;
  } OptionCodeSt;

  // Encoding keeps bit 0 = output entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // One-hot of the lowest writeback port that is valid and targets psrc.
  function automatic logic [WB_WIDTH-1:0] wbHitVec(
    input logic [WB_WIDTH-1:0]             wb,
    input logic [WB_WIDTH-1:0][PREG_W-1:0] pdest,
    input logic [PREG_W-1:0]               psrc
  );
    logic [WB_WIDTH-1:0] hit;
    logic                found;
    hit   = '0;
    found = 1'b0;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (!found && wb[j] && (pdest[j] == psrc)) begin
        hit[j] = 1'b1;
        found  = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/order_issue_stage_skid.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// The upstream ready is taken from registers only, so there is no
// combinational path from out_ready_i to in_ready_o.
module issue_skid_buffer
  import order_issue_stage_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  skid_state_e state_q, state_d;
  T            out_q, out_d;
  T            skid_q, skid_d;
  logic        accept;
  logic        fire;

  assign in_ready_o  = (state_q != SKID_FULL) & ~flush_i;
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = out_q;
  assign accept      = in_valid_i & in_ready_o;
  assign fire        = out_valid_o & out_ready_i;

  // State and payload registers; reset clears both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

  // Next state and entry loads; flush drops everything, including this cycle's accept/fire.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            out_d   = in_data_i;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && fire) begin
            out_d   = in_data_i;
          end else if (accept) begin
            skid_d  = in_data_i;
            state_d = SKID_FULL;
          end else if (fire) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (fire) begin
            out_d   = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: begin
          state_d = SKID_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/order_issue_stage.sv
// Issue stage between an in-order reservation station and its FU.
// Reads both operands from the regfile, overrides them with same-cycle
// writeback data, and hands the uop to a 2-entry skid buffer.
module order_issue_stage
  import order_issue_stage_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter type OPTION_CODE = OptionCodeSt
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush_i,
  input  logic                                 issue_valid_i,
  output logic                                 issue_ready_o,
  input  IssueBaseSt                           issue_base_i,
  input  OPTION_CODE                           issue_oc_i,
  output logic [PREG_W-1:0]                    rf_raddr0_o,
  output logic [PREG_W-1:0]                    rf_raddr1_o,
  input  logic [DATA_WIDTH-1:0]                rf_rdata0_i,
  input  logic [DATA_WIDTH-1:0]                rf_rdata1_i,
  input  logic [WB_WIDTH-1:0]                  wb_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]      wb_pdest_i,
  input  logic [WB_WIDTH-1:0][DATA_WIDTH-1:0]  wb_data_i,
  output logic                                 exe_valid_o,
  input  logic                                 exe_ready_i,
  output IssueBaseSt                           exe_base_o,
  output OPTION_CODE                           exe_oc_o,
  output logic [DATA_WIDTH-1:0]                exe_src0_o,
  output logic [DATA_WIDTH-1:0]                exe_src1_o
);

  typedef struct packed {
    IssueBaseSt            base;
    OPTION_CODE            oc;
    logic [DATA_WIDTH-1:0] src0;
    logic [DATA_WIDTH-1:0] src1;
  } ExeOperandSt;

  ExeOperandSt         in_entry;
  ExeOperandSt         out_entry;
  logic [WB_WIDTH-1:0] hit0;
  logic [WB_WIDTH-1:0] hit1;
  logic [DATA_WIDTH-1:0] src0;
  logic [DATA_WIDTH-1:0] src1;

  assign rf_raddr0_o = issue_base_i.psrc0;
  assign rf_raddr1_o = issue_base_i.psrc1;

  assign hit0 = wbHitVec(wb_i, wb_pdest_i, issue_base_i.psrc0);
  assign hit1 = wbHitVec(wb_i, wb_pdest_i, issue_base_i.psrc1);

  // Operand select: invalid source reads as zero, else bypass wins over regfile.
  always_comb begin
    src0 = rf_rdata0_i;
    src1 = rf_rdata1_i;
    for (int j = 0; j < WB_WIDTH; j++) begin
      if (hit0[j]) src0 = wb_data_i[j];
      if (hit1[j]) src1 = wb_data_i[j];
    end
    if (!issue_base_i.psrc0_valid) src0 = '0;
    if (!issue_base_i.psrc1_valid) src1 = '0;
  end

  assign in_entry.base = issue_base_i;
  assign in_entry.oc   = issue_oc_i;
  assign in_entry.src0 = src0;
  assign in_entry.src1 = src1;

  issue_skid_buffer #(
    .T (ExeOperandSt)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (issue_valid_i),
    .in_ready_o  (issue_ready_o),
    .in_data_i   (in_entry),
    .out_valid_o (exe_valid_o),
    .out_ready_i (exe_ready_i),
    .out_data_o  (out_entry)
  );

  assign exe_base_o = out_entry.base;
  assign exe_oc_o   = out_entry.oc;
  assign exe_src0_o = out_entry.src0;
  assign exe_src1_o = out_entry.src1;

endmodule
